sd_sector_buffer: RTL and testbench

- Core-side single-drive sector client that sits directly upstream of the SD card wrapper.
- Owns a 512-byte sector buffer with a byte-wide random-access core port.
- Translates core read/write sector requests into one rstart/wstart bit plus sector number, holding the request until the wrapper reports done.
- Fills the buffer from the wrapper's outen/outaddr/outbyte stream on reads; serves inbyte at the wrapper's address with 1-cycle latency on writes.

---
 rtl/sd_sector_buffer_if.sv | 23 ++
 rtl/sd_sector_buffer.sv | 132 +++++++++++++
 tb/tb_sd_sector_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_buffer_if.sv
// Link between the sector buffer and the SD card wrapper.
// master = sector buffer (drives start bits/sector/inbyte), slave = wrapper.
interface sd_sector_buffer_if;
   logic        sd_rstart;
   logic        sd_wstart;
   logic [31:0] sd_sector;
   logic        sd_rbusy;
   logic        sd_rdone;
   logic        sd_outen;
   logic [8:0]  sd_outaddr;
   logic [7:0]  sd_outbyte;
   logic [7:0]  sd_inbyte;

   modport master (
      output sd_rstart, sd_wstart, sd_sector, sd_inbyte,
      input  sd_rbusy, sd_rdone, sd_outen, sd_outaddr, sd_outbyte
   );

   modport slave (
      input  sd_rstart, sd_wstart, sd_sector, sd_inbyte,
      output sd_rbusy, sd_rdone, sd_outen, sd_outaddr, sd_outbyte
   );
endinterface

// File: rtl/sd_sector_buffer.sv
// Single-drive sector client: 512-byte dual-port buffer plus request FSM that
// hands read/write sector requests to the SD wrapper and waits for its done.
module sd_sector_buffer #(
   parameter int TIMEOUT_W = 24
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               req_read,
   input  logic               req_write,
   input  logic [31:0]        req_lba,
   output logic               busy,
   output logic               done,
   output logic               err,
   input  logic [8:0]         core_addr,
   input  logic [7:0]         core_wdata,
   input  logic               core_we,
   output logic [7:0]         core_rdata,
   sd_sector_buffer_if.master sd
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, FINISH} state_t;

   localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - 1'b1;
   localparam logic [9:0]           FULL    = 10'd512;

   state_t               state, state_nxt;
   logic                 busy_nxt, done_nxt, err_nxt;
   logic                 rstart, rstart_nxt, wstart, wstart_nxt;
   logic [31:0]          sector, sector_nxt;
   logic [9:0]           cnt, cnt_nxt, cnt_inc;
   logic [TIMEOUT_W-1:0] wd, wd_nxt;
   logic [7:0]           inbyte;
   logic                 timeout, sd_we, core_we_ok;
   logic [7:0]           mem [512];

   assign sd.sd_rstart = rstart;
   assign sd.sd_wstart = wstart;
   assign sd.sd_sector = sector;
   assign sd.sd_inbyte = inbyte;

   assign cnt_inc    = (sd.sd_outen && cnt != FULL) ? cnt + 10'd1 : cnt;
   // Timeout fires as the counter steps onto all-ones, so the start bit is
   // held for exactly 2^TIMEOUT_W-1 wait cycles.
   assign timeout    = (wd == WD_LAST);
   assign sd_we      = (state == RD_WAIT) && sd.sd_outen;
   assign core_we_ok = core_we && (state == IDLE || state == FINISH);

   always_comb begin
      state_nxt  = state;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      err_nxt    = err;
      rstart_nxt = rstart;
      wstart_nxt = wstart;
      sector_nxt = sector;
      cnt_nxt    = cnt;
      wd_nxt     = wd;
      case (state)
         IDLE: begin
            if (req_read || req_write) begin
               sector_nxt = req_lba;
               err_nxt    = 1'b0;
               cnt_nxt    = '0;
               wd_nxt     = '0;
               busy_nxt   = 1'b1;
               if (req_read) begin
                  rstart_nxt = 1'b1;
                  state_nxt  = RD_WAIT;
               end else begin
                  wstart_nxt = 1'b1;
                  state_nxt  = WR_WAIT;
               end
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (state == RD_WAIT) cnt_nxt = cnt_inc;
            wd_nxt = wd + 1'b1;
            // A done arriving on the timeout cycle still counts as completion.
            if (sd.sd_rdone || timeout) begin
               state_nxt  = FINISH;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
               rstart_nxt = 1'b0;
               wstart_nxt = 1'b0;
               if (sd.sd_rdone) err_nxt = (state == RD_WAIT) && (cnt_inc != FULL);
               else             err_nxt = 1'b1;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         rstart <= 1'b0;
         wstart <= 1'b0;
         sector <= '0;
         cnt    <= '0;
         wd     <= '0;
      end else begin
         state  <= state_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         err    <= err_nxt;
         rstart <= rstart_nxt;
         wstart <= wstart_nxt;
         sector <= sector_nxt;
         cnt    <= cnt_nxt;
         wd     <= wd_nxt;
      end
   end

   // Writers are state-exclusive: SD side only while reading, core only when idle.
   always_ff @(posedge clk) begin
      if (sd_we)           mem[sd.sd_outaddr] <= sd.sd_outbyte;
      else if (core_we_ok) mem[core_addr]     <= core_wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         core_rdata <= '0;
         inbyte     <= '0;
      end else begin
         core_rdata <= mem[core_addr];
         inbyte     <= mem[sd.sd_outaddr];
      end
   end
endmodule

// File: tb/tb_sd_sector_buffer.sv
// Self-checking bench for sd_sector_buffer: buffer data goes through a queue
// scoreboard, control outputs are checked at the cycle they must change.
module tb_sd_sector_buffer;
   localparam int TW     = 10;
   localparam int WD_CYC = (1 << TW) - 1;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_read = 1'b0, req_write = 1'b0;
   logic [31:0] req_lba = '0;
   logic        busy, done, err;
   logic [8:0]  core_addr = '0;
   logic [7:0]  core_wdata = '0;
   logic        core_we = 1'b0;
   logic [7:0]  core_rdata;

   int total = 0;
   int bad   = 0;
   logic [7:0] sb[$];

   sd_sector_buffer_if sdi ();

   sd_sector_buffer #(.TIMEOUT_W(TW)) dut (
      .clk(clk), .rstn(rstn),
      .req_read(req_read), .req_write(req_write), .req_lba(req_lba),
      .busy(busy), .done(done), .err(err),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
      .core_rdata(core_rdata),
      .sd(sdi.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_pop(input string tag, input logic [7:0] got);
      logic [7:0] e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk(tag, {24'd0, got}, {24'd0, e});
      end
   endtask

   task automatic request(input bit rd, input bit wr, input logic [31:0] lba);
      req_read  = rd;
      req_write = wr;
      req_lba   = lba;
      tick();
      req_read  = 1'b0;
      req_write = 1'b0;
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         sdi.sd_outen   = 1'b1;
         sdi.sd_outaddr = 9'(i);
         sdi.sd_outbyte = 8'(i) ^ 8'h5A;
         tick();
      end
      sdi.sd_outen = 1'b0;
   endtask

   task automatic finish_rdone(input string tag, input logic exp_err);
      sdi.sd_rdone = 1'b1;
      tick();
      sdi.sd_rdone = 1'b0;
      chk({tag, "_done"},   done, 1);
      chk({tag, "_busy0"},  busy, 0);
      chk({tag, "_rstart0"}, sdi.sd_rstart, 0);
      chk({tag, "_wstart0"}, sdi.sd_wstart, 0);
      chk({tag, "_err"},    err, exp_err);
      tick();
      chk({tag, "_done1cyc"}, done, 0);
   endtask

   initial begin
      int n;
      sdi.sd_rbusy   = 1'b0;
      sdi.sd_rdone   = 1'b0;
      sdi.sd_outen   = 1'b0;
      sdi.sd_outaddr = '0;
      sdi.sd_outbyte = '0;

      // reset state
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rstart", sdi.sd_rstart, 0);
      chk("rst_wstart", sdi.sd_wstart, 0);
      chk("rst_sector", sdi.sd_sector, 0);
      chk("rst_rdata", core_rdata, 0);
      chk("rst_inbyte", sdi.sd_inbyte, 0);
      rstn = 1'b1;
      tick();

      // full read
      request(1, 0, 32'h0000_1234);
      chk("rd_rstart", sdi.sd_rstart, 1);
      chk("rd_busy", busy, 1);
      chk("rd_sector", sdi.sd_sector, 32'h1234);
      stream(512);
      chk("rd_rstart_hold", sdi.sd_rstart, 1);
      finish_rdone("rd", 1'b0);
      for (int a = 0; a < 512; a++) begin
         core_addr = 9'(a);
         sb.push_back(8'(a) ^ 8'h5A);
         tick();
         sb_pop("rd_data", core_rdata);
      end
      core_addr = 9'h1FF;
      tick();
      chk("rd_last_a5", core_rdata, 8'hA5);

      // core fills buffer, then write sector 7
      for (int a = 0; a < 512; a++) begin
         core_we = 1'b1; core_addr = 9'(a); core_wdata = 8'(a);
         tick();
      end
      core_we = 1'b0;
      request(0, 1, 32'd7);
      chk("wr_wstart", sdi.sd_wstart, 1);
      chk("wr_rstart0", sdi.sd_rstart, 0);
      chk("wr_sector", sdi.sd_sector, 7);
      for (int a = 0; a < 512; a++) begin
         sdi.sd_outaddr = 9'(a);
         sb.push_back(8'(a));
         core_we    = (a == 0);
         core_addr  = 9'd5;
         core_wdata = 8'hEE;
         req_write  = (a == 10);
         req_lba    = 32'd9;
         tick();
         sb_pop("wr_inbyte", sdi.sd_inbyte);
      end
      core_we = 1'b0; req_write = 1'b0;
      chk("wr_ignore_req", sdi.sd_sector, 7);
      chk("wr_wstart_hold", sdi.sd_wstart, 1);
      finish_rdone("wr", 1'b0);
      core_addr = 9'd5;
      sb.push_back(8'd5);
      tick();
      sb_pop("wr_core_we_busy", core_rdata);
      chk("wr_idle_after", busy, 0);

      // short read
      request(1, 0, 32'h22);
      stream(500);
      finish_rdone("short", 1'b1);

      // read+write collision, then watchdog timeout
      request(1, 1, 32'h33);
      chk("col_rstart", sdi.sd_rstart, 1);
      chk("col_wstart0", sdi.sd_wstart, 0);
      chk("col_err_clr", err, 0);
      n = 0;
      while (sdi.sd_rstart && n < 4 * WD_CYC) begin
         n++;
         tick();
      end
      chk("to_cycles", n, WD_CYC);
      chk("to_done", done, 1);
      chk("to_err", err, 1);
      chk("to_busy0", busy, 0);
      tick();

      // done coincident with timeout
      request(0, 1, 32'h44);
      repeat (WD_CYC - 1) tick();
      chk("coin_wstart", sdi.sd_wstart, 1);
      finish_rdone("coin", 1'b0);

      // async reset mid-read
      request(1, 0, 32'h55);
      stream(100);
      rstn = 1'b0;
      #1;
      chk("ar_rstart0", sdi.sd_rstart, 0);
      chk("ar_busy0", busy, 0);
      repeat (2) tick();
      chk("ar_nodone", done, 0);
      chk("ar_sector0", sdi.sd_sector, 0);
      rstn = 1'b1;
      tick();
      request(0, 1, 32'd3);
      chk("ar_new_wstart", sdi.sd_wstart, 1);
      chk("ar_new_busy", busy, 1);
      finish_rdone("ar_new", 1'b0);

      chk("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
